// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch stage for the 16-bit CPU. Owns the program
//               counter, captures instr_mem read data into a circular
//               prefetch queue of {pc, instruction} entries, and hands the
//               head to decode over a valid/ready handshake. A branch
//               redirect flushes the queue and restarts fetch.
//               Optional macro FETCH_BOUNDS_EN: stop fetching at PC_LIMIT
//               and raise fetch_done.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_LIMIT = 16'h0032
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [15:0]                pc,
    input  logic [15:0]                instruction,
    input  logic                       redirect,
    input  logic [15:0]                redirect_pc,
    output logic                       if_valid,
    output logic [15:0]                if_instr,
    output logic [15:0]                if_pc,
    input  logic                       id_ready,
    output logic [$clog2(DEPTH):0]     queue_count,
    output logic                       fetch_done
);

    localparam int                c_AW        = $clog2(DEPTH);
    localparam int                c_CW        = c_AW + 1;
    localparam logic [c_CW-1:0]   c_DEPTH_CNT = c_CW'(DEPTH);

    logic [15:0]      r_fetch_pc;
    logic [c_AW-1:0]  r_head;
    logic [c_AW-1:0]  r_tail;
    logic [c_CW-1:0]  r_count;
    logic [15:0]      r_mem_pc    [DEPTH];
    logic [15:0]      r_mem_instr [DEPTH];

    logic             w_halt;
    logic             w_pop;
    logic             w_push;
    logic             w_not_empty;

`ifdef FETCH_BOUNDS_EN
    // Fetch stops once the PC leaves the valid ROM window.
    assign w_halt = (r_fetch_pc >= PC_LIMIT);
`else
    // Unbounded fetch; the limit has no meaning in this build.
    logic w_unused_limit;
    assign w_unused_limit = ^PC_LIMIT;
    assign w_halt         = 1'b0;
`endif

    assign w_not_empty = (r_count != '0);
    // A redirect masks the head so decode never accepts a squashed entry.
    assign if_valid    = w_not_empty & ~redirect;
    assign w_pop       = if_valid & id_ready;
    // Pushing into a full queue is fine when the head leaves in the same cycle.
    assign w_push      = ~redirect & ~w_halt & ((r_count < c_DEPTH_CNT) | w_pop);

    assign pc          = r_fetch_pc;
    assign queue_count = r_count;
    assign fetch_done  = w_halt;
    assign if_instr    = w_not_empty ? r_mem_instr[r_head] : 16'h0000;
    assign if_pc       = w_not_empty ? r_mem_pc[r_head]    : 16'h0000;

    // Pointer, count and PC update; reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[15:1], 1'b0};
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 16'd2;
                r_tail     <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage: cleared on reset, written at the tail on every push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= 16'h0000;
                r_mem_instr[i] <= 16'h0000;
            end
        end else if (w_push) begin
            r_mem_pc[r_tail]    <= r_fetch_pc;
            r_mem_instr[r_tail] <= instruction;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch (DEPTH = 4, RESET_PC = 0,
//               PC_LIMIT = 0x0032). A vector table covers streaming,
//               backpressure, redirect and reset; hand-written sequences
//               cover full-queue draining, redirect with three entries,
//               16-bit PC wrap or the fetch bound (FETCH_BOUNDS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        id_ready;
    logic [2:0]  queue_count;
    logic        fetch_done;

    int n_tests;
    int n_fail;

    instr_fetch #(
        .DEPTH    (4),
        .RESET_PC (16'h0000),
        .PC_LIMIT (16'h0032)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .instruction (instruction),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .queue_count (queue_count),
        .fetch_done  (fetch_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: byte-swapped address XOR a constant, so every word is distinct.
    function automatic logic [15:0] rom(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    assign instruction = rom(pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        redirect;
        logic [15:0] redirect_pc;
        logic        id_ready;
        logic        exp_valid;
        logic [15:0] exp_pc;
        logic [15:0] exp_if_pc;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[19];

    initial begin
        logic [15:0] last_pc;
        logic [15:0] exp_instr;
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        id_ready    = 1'b0;

        // Outputs are checked inside the cycle, before the edge that applies the inputs.
        //           rst  red  rpc       rdy  valid pc        if_pc     cnt
        vecs[0]  = '{1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0000,16'h0000,3'd0};
        vecs[1]  = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'h0002,16'h0000,3'd1};
        vecs[2]  = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'h0004,16'h0002,3'd1};
        vecs[3]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0006,16'h0004,3'd1};
        vecs[4]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0008,16'h0004,3'd2};
        vecs[5]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'h000A,16'h0004,3'd3};
        vecs[6]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'h000C,16'h0004,3'd4};
        vecs[7]  = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'h000C,16'h0004,3'd4};
        vecs[8]  = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'h000C,16'h0004,3'd4};
        vecs[9]  = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'h000E,16'h0006,3'd4};
        vecs[10] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0010,16'h0008,3'd4};
        vecs[11] = '{1'b1,1'b1,16'h0015,1'b1,1'b0,16'h0010,16'h0008,3'd4};
        vecs[12] = '{1'b1,1'b0,16'h0000,1'b1,1'b0,16'h0014,16'h0000,3'd0};
        vecs[13] = '{1'b1,1'b0,16'h0000,1'b1,1'b1,16'h0016,16'h0014,3'd1};
        vecs[14] = '{1'b1,1'b1,16'h0003,1'b1,1'b0,16'h0018,16'h0016,3'd1};
        vecs[15] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0002,16'h0000,3'd0};
        vecs[16] = '{1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0004,16'h0002,3'd1};
        vecs[17] = '{1'b0,1'b0,16'h0000,1'b1,1'b1,16'h0006,16'h0002,3'd2};
        vecs[18] = '{1'b1,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,3'd0};

        do_reset();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 19; i++) begin
            rst_n       = vecs[i].rst_n;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].redirect_pc;
            id_ready    = vecs[i].id_ready;
            #2;
            exp_instr = (vecs[i].exp_count != 3'd0) ? rom(vecs[i].exp_if_pc) : 16'h0000;
            chk($sformatf("v%0d.if_valid", i),    {31'd0, if_valid},   {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d.pc", i),          {16'd0, pc},         {16'd0, vecs[i].exp_pc});
            chk($sformatf("v%0d.if_pc", i),       {16'd0, if_pc},      {16'd0, vecs[i].exp_if_pc});
            chk($sformatf("v%0d.if_instr", i),    {16'd0, if_instr},   {16'd0, exp_instr});
            chk($sformatf("v%0d.queue_count", i), {29'd0, queue_count},{29'd0, vecs[i].exp_count});
            chk($sformatf("v%0d.fetch_done", i),  {31'd0, fetch_done}, 32'd0);
            tick();
        end
        redirect = 1'b0;
        rst_n    = 1'b1;

        // ---------------- backpressure then full with simultaneous pop ----------------
        do_reset();
        id_ready = 1'b0;
        repeat (6) tick();
        chk("bp.count_full", {29'd0, queue_count}, 32'd4);
        chk("bp.pc_frozen",  {16'd0, pc},          32'h0008);
        chk("bp.head_pc",    {16'd0, if_pc},       32'h0000);
        id_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("full_pop%0d.if_pc", k),    {16'd0, if_pc},      32'(2 * k));
            chk($sformatf("full_pop%0d.if_instr", k), {16'd0, if_instr},   {16'd0, rom(16'(2 * k))});
            chk($sformatf("full_pop%0d.count", k),    {29'd0, queue_count},32'd4);
            chk($sformatf("full_pop%0d.pc", k),       {16'd0, pc},         32'(8 + 2 * k));
            tick();
        end

        // ---------------- redirect with three entries queued ----------------
        do_reset();
        id_ready = 1'b0;
        repeat (3) tick();
        chk("rd.count3", {29'd0, queue_count}, 32'd3);
        redirect    = 1'b1;
        redirect_pc = 16'h0015;
        #1;
        chk("rd.valid_same_cycle", {31'd0, if_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        chk("rd.count_next", {29'd0, queue_count}, 32'd0);
        chk("rd.pc_next",    {16'd0, pc},          32'h0014);
        tick();
        chk("rd.valid_after", {31'd0, if_valid}, 32'd1);
        chk("rd.if_pc_after", {16'd0, if_pc},    32'h0014);
        chk("rd.if_instr",    {16'd0, if_instr}, {16'd0, rom(16'h0014)});

`ifndef FETCH_BOUNDS_EN
        // ---------------- 16-bit PC wrap ----------------
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        chk("wrap.pc_fffe", {16'd0, pc}, 32'hFFFE);
        tick();
        chk("wrap.if_pc_fffe", {16'd0, if_pc}, 32'hFFFE);
        chk("wrap.pc_0000",    {16'd0, pc},    32'h0000);
        tick();
        chk("wrap.if_pc_0000", {16'd0, if_pc}, 32'h0000);
        chk("wrap.fetch_done", {31'd0, fetch_done}, 32'd0);
`else
        // ---------------- fetch bound ----------------
        do_reset();
        id_ready = 1'b1;
        last_pc  = 16'hDEAD;
        begin : g_bound_run
            for (int k = 0; k < 100; k++) begin
                #1;
                if (if_valid) last_pc = if_pc;
                if (fetch_done) disable g_bound_run;
                tick();
            end
        end
        chk("bnd.fetch_done", {31'd0, fetch_done}, 32'd1);
        chk("bnd.pc_limit",   {16'd0, pc},         32'h0032);
        repeat (6) begin
            tick();
            if (if_valid) last_pc = if_pc;
        end
        chk("bnd.last_if_pc", {16'd0, last_pc},     32'h0030);
        chk("bnd.drained",    {29'd0, queue_count}, 32'd0);
        chk("bnd.pc_held",    {16'd0, pc},          32'h0032);
        redirect    = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        chk("bnd.done_clear", {31'd0, fetch_done}, 32'd0);
        chk("bnd.pc_restart", {16'd0, pc},         32'h0000);
        tick();
        chk("bnd.resume_if_pc", {16'd0, if_pc},    32'h0000);
        chk("bnd.resume_valid", {31'd0, if_valid}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit CPU, directly upstream of `instr_mem`. It owns the program counter and drives `pc` to the instruction memory. It captures the 16-bit `instruction` returned in the same cycle into a small prefetch queue. It presents queued instructions, tagged with their PC, to the decode stage over a valid/ready handshake, and flushes and restarts on a branch redirect.

## Interface
- `DEPTH`, 4: prefetch queue entries; power of two, 2..16.
- `RESET_PC`, 16'h0000: fetch address after reset; must be even.
- `PC_LIMIT`, 16'h0032: first byte address beyond valid program ROM; used only with `FETCH_BOUNDS_EN`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pc` out 16: fetch byte address to `instr_mem`; always equals the internal `fetch_pc` register.
- `instruction` in 16: `instr_mem` read data for `pc`, combinational, valid in the same cycle.
- `redirect` in 1: branch/jump taken; flush the queue and restart fetch.
- `redirect_pc` in 16: new fetch address; bit 0 is ignored (forced to 0).
- `if_valid` out 1: queue head is valid for decode.
- `if_instr` out 16: queue head instruction.
- `if_pc` out 16: PC of the queue head instruction.
- `id_ready` in 1: decode accepts the head this cycle.
- `queue_count` out $clog2(DEPTH)+1: number of occupied entries, 0..DEPTH.
- `fetch_done` out 1: fetch halted at `PC_LIMIT`; constant 0 without `FETCH_BOUNDS_EN`.

## Operation
- The queue is a circular buffer of {pc, instruction} entries with a head pointer, a tail pointer and a count. The pointers wrap modulo DEPTH.
- `pop` = `if_valid & id_ready`.
- `push` = `!redirect & !halt & (count < DEPTH | pop)`.
  - `halt` = (`fetch_pc >= PC_LIMIT`) with `FETCH_BOUNDS_EN`, and 0 otherwise.
- On `push`, write {`fetch_pc`, `instruction`} at the tail, then `fetch_pc <= fetch_pc + 2`. The addition is 16-bit modulo: 16'hFFFE wraps to 16'h0000.
- On `pop`, advance the head.
- Simultaneous push and pop leave the count unchanged. A push is allowed while full if a pop occurs in the same cycle.
- `if_valid` = `(count != 0) & !redirect`.
- `if_instr` and `if_pc` show the head entry when count != 0, and 16'h0000 when the queue is empty.
- On `redirect`:
  - count, head and tail are cleared to 0.
  - `fetch_pc <= {redirect_pc[15:1], 1'b0}`.
  - No push and no pop occur that cycle; the head is discarded, not transferred.
- `fetch_done` = `halt`. It is held until a redirect or reset sets `fetch_pc` below `PC_LIMIT`. While halted, the queue keeps draining normally.
- Reset (`rst_n` == 0 at an edge) has priority over redirect, push and pop. It sets:
  - `fetch_pc = RESET_PC`;
  - count, head and tail to 0;
  - all storage to 0.
- Reset after reset: `if_valid` = 0, `if_instr` = `if_pc` = 0, `queue_count` = 0, `pc` = `RESET_PC`. `fetch_done` = 0 unless `RESET_PC >= PC_LIMIT` with the macro defined.
- Reset asserted mid-stream discards all queued entries at that edge.

## Timing
- Fetch-to-decode latency is 1 cycle. An instruction at `pc` in cycle N is pushed at edge N and appears on `if_*` in cycle N+1 if the queue was empty. There is no same-cycle bypass.
- Sustained throughput is 1 instruction/cycle while `id_ready` = 1.
- Redirect latency:
  - Redirect is asserted in cycle N.
  - `pc` = target in cycle N+1, and the target is pushed at edge N+1.
  - The first target instruction shows `if_valid` in cycle N+2.
- `if_valid` depends combinationally on `redirect`. All other outputs are driven from registers.
- With `id_ready` = 0 and the queue full, `pc` holds steady and the queue contents are unchanged.

## Configuration
- `FETCH_BOUNDS_EN` defined: fetch stops at `fetch_pc >= PC_LIMIT` and `fetch_done` asserts. No out-of-ROM zero words enter the queue.
- `FETCH_BOUNDS_EN` undefined: `halt` = 0 and `fetch_done` is tied to 0. `PC_LIMIT` is unused. Fetch runs unbounded with 16-bit wrap, and words from beyond the ROM enter the queue as returned by `instr_mem`.

## Test plan
- **Reset and streaming:** release reset with `id_ready` = 1 and a ROM model.
  - Cycle 1: `if_valid` = 1, `if_pc` = 0x0000.
  - Then `if_pc` = 0x0002, 0x0004, … each cycle, and `if_instr` matches the ROM word.
- **Backpressure:** hold `id_ready` = 0, DEPTH = 4.
  - After 4 pushes: `queue_count` = 4, `pc` frozen at 0x0008.
  - Raise `id_ready`: `if_pc` = 0x0000, 0x0002, … in order, with no loss or duplicates.
- **Full with simultaneous pop:** queue full and `id_ready` = 1.
  - Push and pop occur in the same cycle, `queue_count` stays 4, and `pc` advances by 2 each cycle.
- **Redirect:** pulse `redirect` with `redirect_pc` = 0x0015 while 3 entries are queued.
  - Same cycle: `if_valid` = 0.
  - Next cycle: `queue_count` = 0, `pc` = 0x0014.
  - Following cycle: `if_pc` = 0x0014.
- **Bounds (macro on):** `PC_LIMIT` = 0x0032.
  - The last pushed `if_pc` is 0x0030, and `fetch_done` = 1 with `pc` = 0x0032.
  - Redirect to 0x0000 clears `fetch_done` and fetch resumes.
- **Wrap and reset mid-stream (macro off):**
  - `redirect_pc` = 0xFFFE gives pushed PCs 0xFFFE then 0x0000.
  - `rst_n` = 0 for one edge with a full queue: `queue_count` = 0, `if_valid` = 0, `pc` = `RESET_PC` in the next cycle.
